// File: rtl/sqrt_range_reduce.sv
// Normalizes a 32-bit unsigned operand by shifting out leading zeros serially.
// Reports the shift count and the top 22 mantissa bits. Define SQRT_EVEN_EXP_EN
// to shift two bits per cycle, which yields an even exponent for square-root use.
module sqrt_range_reduce (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iValid,
    input  logic [31:0] iX,
    output logic        oBusy,
    output logic        oValid,
    output logic [5:0]  oExp_f,
    output logic [21:0] oY_f
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

`ifdef SQRT_EVEN_EXP_EN
    localparam int unsigned STEP     = 2;
    localparam logic [5:0]  STEP_CNT = 6'd2;
`else
    localparam int unsigned STEP     = 1;
    localparam logic [5:0]  STEP_CNT = 6'd1;
`endif

    logic [1:0]  r_state_reg, w_state_next;
    logic [31:0] r_shift_reg, w_shift_next;
    logic [5:0]  r_cnt_reg,   w_cnt_next;
    logic        r_busy_reg,  w_busy_next;
    logic        r_valid_reg, w_valid_next;
    logic [5:0]  r_exp_reg,   w_exp_next;
    logic [21:0] r_y_reg,     w_y_next;

    logic w_accept;
    logic w_zero;
    logic w_norm;

    assign w_accept = iValid && !r_busy_reg;
    assign w_zero   = (r_shift_reg == 32'd0);

    // In the even-exponent build a mantissa with only bit 30 set is accepted.
`ifdef SQRT_EVEN_EXP_EN
    assign w_norm = |r_shift_reg[31:30];
`else
    assign w_norm = r_shift_reg[31];
`endif

    always_comb begin
        w_state_next = r_state_reg;
        w_shift_next = r_shift_reg;
        w_cnt_next   = r_cnt_reg;
        w_busy_next  = r_busy_reg;
        w_valid_next = 1'b0;
        w_exp_next   = r_exp_reg;
        w_y_next     = r_y_reg;
        case (r_state_reg)
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    w_state_next = ST_SHIFT;
                    w_shift_next = iX;
                    w_cnt_next   = 6'd0;
                    w_busy_next  = 1'b1;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (w_zero) begin
                    w_state_next = ST_DONE;
                    w_busy_next  = 1'b0;
                    w_valid_next = 1'b1;
                    w_exp_next   = 6'd32;
                    w_y_next     = 22'd0;
                end else if (w_norm) begin
                    w_state_next = ST_DONE;
                    w_busy_next  = 1'b0;
                    w_valid_next = 1'b1;
                    w_exp_next   = r_cnt_reg;
                    w_y_next     = r_shift_reg[31:10];
                end else begin
                    w_shift_next = r_shift_reg << STEP;
                    w_cnt_next   = r_cnt_reg + STEP_CNT;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state_reg <= ST_IDLE;
            r_shift_reg <= 32'd0;
            r_cnt_reg   <= 6'd0;
            r_busy_reg  <= 1'b0;
            r_valid_reg <= 1'b0;
            r_exp_reg   <= 6'd0;
            r_y_reg     <= 22'd0;
        end else begin
            r_state_reg <= w_state_next;
            r_shift_reg <= w_shift_next;
            r_cnt_reg   <= w_cnt_next;
            r_busy_reg  <= w_busy_next;
            r_valid_reg <= w_valid_next;
            r_exp_reg   <= w_exp_next;
            r_y_reg     <= w_y_next;
        end
    end

    assign oBusy  = r_busy_reg;
    assign oValid = r_valid_reg;
    assign oExp_f = r_exp_reg;
    assign oY_f   = r_y_reg;

endmodule

// File: tb/tb_sqrt_range_reduce.sv
// Self-checking bench for sqrt_range_reduce: directed corner cases plus
// randomized operands compared against a leading-zero-count reference model.
module tb_sqrt_range_reduce;

    logic        iClk = 1'b0;
    logic        iRst = 1'b1;
    logic        iValid = 1'b0;
    logic [31:0] iX = 32'd0;
    logic        oBusy;
    logic        oValid;
    logic [5:0]  oExp_f;
    logic [21:0] oY_f;

    int n_vec  = 0;
    int n_miss = 0;

    sqrt_range_reduce dut (
        .iClk   (iClk),
        .iRst   (iRst),
        .iValid (iValid),
        .iX     (iX),
        .oBusy  (oBusy),
        .oValid (oValid),
        .oExp_f (oExp_f),
        .oY_f   (oY_f)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // Reference: exponent is the leading-zero count (rounded down to even in
    // the even build); mantissa is the top 22 bits after that shift.
    function automatic void ref_model(input logic [31:0] x, output logic [5:0] e,
                                      output logic [21:0] y, output int lat);
        int lz;
        int sh;
        logic [31:0] t;
        lz = 0;
        while (lz < 32 && x[31-lz] == 1'b0) lz++;
        if (x == 32'd0) begin
            e = 6'd32; y = 22'd0; lat = 1;
        end else begin
`ifdef SQRT_EVEN_EXP_EN
            sh  = lz - (lz % 2);
            lat = lz / 2 + 1;
`else
            sh  = lz;
            lat = lz + 1;
`endif
            t = x << sh;
            e = 6'(sh);
            y = t[31:10];
        end
    endfunction

    task automatic drive_accept(input logic [31:0] x);
        iValid = 1'b1;
        iX     = x;
        @(posedge iClk); #1;
        iValid = 1'b0;
        iX     = $urandom;
        chk("busy_after_accept", 32'(oBusy), 32'd1);
    endtask

    // Called #1 after the acceptance edge (or 'start' edges later); returns
    // #1 after the edge that raised oValid.
    task automatic wait_result(input string tag, input logic [5:0] e, input logic [21:0] y,
                               input int lat, input int start);
        int n;
        n = start;
        while (!oValid && n < 40) begin
            @(posedge iClk); #1;
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(lat));
        chk({tag, "_exp"}, 32'(oExp_f), 32'(e));
        chk({tag, "_y"}, 32'(oY_f), 32'(y));
        chk({tag, "_busy_low"}, 32'(oBusy), 32'd0);
        $display("op %s: exp=%0d y=%06h latency=%0d", tag, oExp_f, oY_f, n);
    endtask

    task automatic check_hold(input string tag, input logic [5:0] e, input logic [21:0] y);
        @(posedge iClk); #1;
        chk({tag, "_pulse_end"}, 32'(oValid), 32'd0);
        chk({tag, "_hold_exp"}, 32'(oExp_f), 32'(e));
        chk({tag, "_hold_y"}, 32'(oY_f), 32'(y));
    endtask

    task automatic run_op(input string tag, input logic [31:0] x);
        logic [5:0]  e;
        logic [21:0] y;
        int lat;
        ref_model(x, e, y, lat);
        drive_accept(x);
        wait_result(tag, e, y, lat, 0);
        check_hold(tag, e, y);
    endtask

    initial begin
        logic [5:0]  e, e2;
        logic [21:0] y, y2;
        int lat, lat2, extra;
        logic [31:0] x;

        repeat (3) @(posedge iClk);
        #1;
        chk("rst_busy", 32'(oBusy), 32'd0);
        chk("rst_valid", 32'(oValid), 32'd0);
        chk("rst_exp", 32'(oExp_f), 32'd0);
        chk("rst_y", 32'(oY_f), 32'd0);
        iRst = 1'b0;

        // Directed corners with explicit expectations.
        drive_accept(32'h8000_0000);
        wait_result("msb", 6'd0, 22'h200000, 1, 0);
        check_hold("msb", 6'd0, 22'h200000);
        drive_accept(32'h0000_0001);
`ifdef SQRT_EVEN_EXP_EN
        wait_result("lsb", 6'd30, 22'h100000, 16, 0);
        check_hold("lsb", 6'd30, 22'h100000);
`else
        wait_result("lsb", 6'd31, 22'h200000, 32, 0);
        check_hold("lsb", 6'd31, 22'h200000);
`endif
        drive_accept(32'h0001_0000);
`ifdef SQRT_EVEN_EXP_EN
        wait_result("b16", 6'd14, 22'h100000, 8, 0);
`else
        wait_result("b16", 6'd15, 22'h200000, 16, 0);
`endif

        // Zero immediately after a result, then back-to-back acceptance in the oValid cycle.
        drive_accept(32'h0);
        wait_result("zero", 6'd32, 22'h0, 1, 0);
        drive_accept(32'h0003_0000);
`ifdef SQRT_EVEN_EXP_EN
        wait_result("b2b", 6'd14, 22'h300000, 8, 0);
`else
        wait_result("b2b", 6'd14, 22'h300000, 15, 0);
`endif
        check_hold("b2b", 6'd14, 22'h300000);

        // A pulse while busy must be dropped.
        ref_model(32'h1, e, y, lat);
        drive_accept(32'h1);
        repeat (2) begin @(posedge iClk); #1; end
        iValid = 1'b1;
        iX     = 32'hFFFF_FFFF;
        @(posedge iClk); #1;
        iValid = 1'b0;
        wait_result("ignore", e, y, lat, 3);
        extra = 0;
        repeat (40) begin
            @(posedge iClk); #1;
            if (oValid) extra++;
        end
        chk("ignore_no_extra", 32'(extra), 32'd0);

        // Reset aborts an operation in progress.
        drive_accept(32'h0000_0100);
        extra = 0;
        repeat (4) begin
            @(posedge iClk); #1;
            if (oValid) extra++;
        end
        iRst = 1'b1;
        @(posedge iClk); #1;
        chk("abort_no_valid", 32'(extra), 32'd0);
        chk("abort_busy", 32'(oBusy), 32'd0);
        chk("abort_valid", 32'(oValid), 32'd0);
        chk("abort_exp", 32'(oExp_f), 32'd0);
        chk("abort_y", 32'(oY_f), 32'd0);
        iRst = 1'b0;
        run_op("post_rst", 32'h0040_1234);

        // Randomized operands with varied leading-zero counts, gaps and back-to-back.
        for (int i = 0; i < 80; i++) begin
            x = ($urandom_range(0, 9) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            ref_model(x, e, y, lat);
            drive_accept(x);
            wait_result($sformatf("rnd%0d", i), e, y, lat, 0);
            if ($urandom_range(0, 2) == 0) begin
                x = $urandom >> $urandom_range(0, 31);
                ref_model(x, e2, y2, lat2);
                drive_accept(x);
                wait_result($sformatf("rnd%0d_b2b", i), e2, y2, lat2, 0);
                check_hold($sformatf("rnd%0d_b2b", i), e2, y2);
            end else begin
                check_hold($sformatf("rnd%0d", i), e, y);
            end
            repeat ($urandom_range(0, 3)) begin @(posedge iClk); #1; end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/sqrt_range_reduce.md
SQRT_RANGE_REDUCE -- requirements
Module: sqrt_range_reduce

Interface
REQ-001 SHALL have port: iClk  input  1  sole clock; all state on rising edge.
REQ-002 SHALL have port: iRst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: iValid  input  1  iX valid this cycle.
REQ-004 SHALL have port: iX  input  32  unsigned operand to normalize.
REQ-005 SHALL have port: oBusy  output  1  high while an operand is in process; iValid ignored while high.
REQ-006 SHALL have port: oValid  output  1  one-cycle pulse marking valid oExp/oY_f.
REQ-007 SHALL have port: oExp_f  output  6  normalization shift count (exponent) for the downstream reconstruction stage.
REQ-008 SHALL have port: oY_f  output  22  normalized mantissa.

Function
REQ-009 SHALL accept an operand on an edge where iValid=1 and oBusy=0, capturing iX into a 32-bit shift register and clearing a 6-bit shift counter.
REQ-010 SHALL implement FSM states IDLE, SHIFT, DONE; IDLE->SHIFT on acceptance; SHIFT->DONE on termination; DONE->IDLE, or DONE->SHIFT if a new operand is accepted in DONE.
REQ-011 SHALL, in SHIFT with shift register zero, terminate with oExp_f=32 and oY_f=0.
REQ-012 SHALL, in SHIFT with bit 31 set, terminate with oExp_f=counter and oY_f=register[31:10] (truncation, no rounding).
REQ-013 SHALL otherwise shift the register left by 1 and increment the counter by 1 per cycle.
REQ-014 SHALL produce oExp_f equal to the leading-zero count lz of iX (0..31), or 32 for iX=0.
REQ-015 SHALL assert oValid for exactly one cycle, lz+1 edges after the acceptance edge (1 edge for iX=0).
REQ-016 SHALL hold oExp_f and oY_f stable from oValid assertion until the next result is loaded.
REQ-017 SHALL hold oBusy high from the acceptance edge until the edge asserting oValid; oBusy=0 during the oValid cycle, so back-to-back acceptance is possible.
REQ-018 SHALL drop iValid pulses arriving while oBusy=1, with no effect on the operation in progress.

Reset
REQ-019 SHALL, on iRst=1 at an edge, force state IDLE, oBusy=0, oValid=0, oExp_f=0, oY_f=0, counter=0, shift register=0.
REQ-020 SHALL give iRst priority over acceptance, aborting any operation in progress without producing oValid.

Configuration
REQ-021 SHALL, with macro SQRT_EVEN_EXP_EN defined, shift by 2 per SHIFT cycle and terminate when register[31:30]!=0, so oExp_f is lz rounded down to even.
REQ-022 SHALL, with SQRT_EVEN_EXP_EN defined, give latency floor(lz/2)+1 edges, with oY_f=register[31:10], allowing oY_f[21]=0.
REQ-023 SHALL, without SQRT_EVEN_EXP_EN, behave per REQ-011..REQ-015.
REQ-024 SHALL, in both builds, report iX=0 as oExp_f=32, oY_f=0, with 1-edge latency.

Verification
REQ-025 SHALL cover: iX=0x80000000 -> oExp_f=0, oY_f=0x200000, oValid 1 edge after acceptance.
REQ-026 SHALL cover: iX=0x00000001 -> oExp_f=31, oY_f=0x200000, oValid 32 edges after acceptance (macro: oExp_f=30, oY_f=0x100000, 16 edges).
REQ-027 SHALL cover: iX=0x00010000 with SQRT_EVEN_EXP_EN -> oExp_f=14, oY_f=0x100000, 8 edges; without macro -> oExp_f=15, oY_f=0x200000, 16 edges.
REQ-028 SHALL cover: iX=0 -> oExp_f=32, oY_f=0, 1 edge; then iX=0x00030000 accepted in the oValid cycle -> oExp_f=14, oY_f=0x300000.
REQ-029 SHALL cover: iX=0x00000001 accepted, iValid with iX=0xFFFFFFFF pulsed 3 edges later -> second operand ignored, single result oExp_f=31.
REQ-030 SHALL cover: iRst asserted 5 edges after accepting iX=0x00000100 -> no oValid; all outputs 0 next cycle; a new operand is accepted immediately after iRst falls.
